// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Two-requester round-robin arbiter in front of a single-port synchronous
// SRAM. Every access takes four cycles: IDLE (arbitrate and latch the
// command) -> ACCESS (drive the SRAM) -> CAPTURE (wait for read data) ->
// DONE (completion pulse visible) -> IDLE.
//
// Handshake: a requester raises mX_req with a stable command (write, addr,
// wdata) and holds it until it sees mX_ready high for one cycle. The command
// is latched at the granting edge, so dropping req after the grant does not
// cancel the access. Changes on req or the command outside IDLE are ignored.
//
// Ports
//   hclk, hrst            clock, asynchronous active-high reset
//   mX_req/write/addr/wdata  requester X command inputs (X = 0, 1)
//   mX_ready              registered one-cycle completion pulse
//   mX_rdata              registered read data, updated on reads only
//   sram_addr, sram_din   latched command towards the SRAM
//   sram_dout             SRAM read data, valid one clock after access edge
//   sram_en, sram_we      SRAM enable / write enable, high only in ACCESS
//   grant                 current or last owner (0 = m0, 1 = m1)
//   busy                  high in any state other than IDLE
// ---------------------------------------------------------------------------
module sram_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int WORD_WIDTH = 8
) (
    input  logic                  hclk,
    input  logic                  hrst,
    input  logic                  m0_req,
    input  logic                  m0_write,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [WORD_WIDTH-1:0] m0_wdata,
    output logic                  m0_ready,
    output logic [WORD_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_write,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [WORD_WIDTH-1:0] m1_wdata,
    output logic                  m1_ready,
    output logic [WORD_WIDTH-1:0] m1_rdata,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [WORD_WIDTH-1:0] sram_din,
    input  logic [WORD_WIDTH-1:0] sram_dout,
    output logic                  sram_we,
    output logic                  sram_en,
    output logic                  grant,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic   cmd_write;
    logic   any_req;
    logic   pick_m1;

    // grant holds the last owner, so on a tie the other requester wins.
    // After reset grant is 1, which hands the first tie to m0.
    assign any_req = m0_req | m1_req;
    assign pick_m1 = m1_req & (~m0_req | ~grant);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and SRAM strobes
    // ------------------------------------------------------------------
    // The strobes are decoded from the state register so that an
    // asynchronous reset removes them at once, without waiting for a clock.
    always_comb begin
        state_next = state;
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_req) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                sram_en    = 1'b1;
                sram_we    = cmd_write;
                state_next = CAPTURE;
            end
            CAPTURE: begin
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command latch, read-data capture and completion pulses
    // ------------------------------------------------------------------
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            grant     <= 1'b1;
            cmd_write <= 1'b0;
            sram_addr <= '0;
            sram_din  <= '0;
            m0_ready  <= 1'b0;
            m1_ready  <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            // Ready is a single-cycle pulse: cleared unless set below.
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant     <= pick_m1;
                        cmd_write <= pick_m1 ? m1_write : m0_write;
                        sram_addr <= pick_m1 ? m1_addr  : m0_addr;
                        sram_din  <= pick_m1 ? m1_wdata : m0_wdata;
                    end
                end
                CAPTURE: begin
                    // sram_dout is valid here, one clock after the access edge.
                    if (!cmd_write) begin
                        if (grant) begin
                            m1_rdata <= sram_dout;
                        end else begin
                            m0_rdata <= sram_dout;
                        end
                    end
                    m0_ready <= ~grant;
                    m1_ready <= grant;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
